// File: rtl/panel_correct_offset_sat_mc.sv
// panel_correct_offset_sat_mc: adds a per-coefficient signed offset to a
// streamed unsigned sample and saturates the sum to the unsigned DW-bit range.
// Latency 2 registers (sample/offset sum, then saturate); no backpressure, one sample per cycle.
// Ports:
//   clk, rst                       clock, async active-high reset
//   wr_en, wr_addr, wr_data        offset table write port (wr_data[DW-1:0] two's complement)
//   din_valid, din_coef, din       sample stream (din[DW-1:0] unsigned)
//   dout_valid, dout, dout_sat     result stream; dout_sat[1]=clipped high, [0]=clipped low
//   wr_err                         one-cycle pulse after a write to wr_addr >= NCOEF
// Optional: define PANEL_CORRECT_SAT_CNT_EN to add cnt_clr, sat_hi_cnt, sat_lo_cnt
//   (saturating counters of clipped-high / clipped-low results).
module panel_correct_offset_sat_mc #(
  parameter int DW    = 13,
  parameter int NCOEF = 9,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          din_valid,
  input  logic [AW-1:0] din_coef,
  input  logic [15:0]   din,
  output logic          dout_valid,
  output logic [15:0]   dout,
  output logic [1:0]    dout_sat,
  output logic          wr_err
`ifdef PANEL_CORRECT_SAT_CNT_EN
  ,
  input  logic          cnt_clr,
  output logic [15:0]   sat_hi_cnt,
  output logic [15:0]   sat_lo_cnt
`endif
);

  localparam logic [AW:0] NCOEF_W = (AW+1)'(NCOEF);

  // Upper bits of the 16-bit buses carry nothing for this stage.
  logic unused_bits;
  assign unused_bits = ^{wr_data[15:DW], din[15:DW]};

  // ---------------------------------------------------------------------------
  // Offset table
  // ---------------------------------------------------------------------------
  logic [DW-1:0] off_tab [NCOEF];

  // Address decode is done by comparing against each entry's constant index so
  // out-of-range addresses simply match nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) off_tab[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NCOEF; i++) begin
        if (wr_addr == AW'(i)) off_tab[i] <= wr_data[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_en && ({1'b0, wr_addr} >= NCOEF_W);
  end

  // ---------------------------------------------------------------------------
  // Stage 1: offset lookup and widened sum
  // ---------------------------------------------------------------------------
  // The table is read combinationally, so a write in the same cycle is not
  // yet visible: the sample sees the old offset.
  logic [DW-1:0] sel_off;
  always_comb begin
    sel_off = '0;
    for (int i = 0; i < NCOEF; i++) begin
      if (din_coef == AW'(i)) sel_off = off_tab[i];
    end
  end

  // Two guard bits: bit DW+1 set means negative, bits 01 mean overflow above max.
  logic [DW+1:0] sum_d;
  assign sum_d = {2'b00, din[DW-1:0]} + {{2{sel_off[DW-1]}}, sel_off};

  logic          s1_vld;
  logic [DW+1:0] s1_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_sum <= '0;
    end else begin
      s1_vld <= din_valid;
      s1_sum <= din_valid ? sum_d : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturate and zero-extend
  // ---------------------------------------------------------------------------
  logic [DW-1:0] res_d;
  logic [1:0]    sat_d;

  always_comb begin
    res_d = '0;
    sat_d = 2'b00;
    if (s1_vld) begin
      case (s1_sum[DW+1:DW])
        2'b00: begin
          res_d = s1_sum[DW-1:0];
          sat_d = 2'b00;
        end
        2'b01: begin
          res_d = '1;
          sat_d = 2'b10;
        end
        default: begin
          res_d = '0;
          sat_d = 2'b01;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_sat   <= 2'b00;
    end else begin
      dout_valid <= s1_vld;
      dout       <= {{(16-DW){1'b0}}, res_d};
      dout_sat   <= sat_d;
    end
  end

`ifdef PANEL_CORRECT_SAT_CNT_EN
  // Counts results as they leave the block; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (cnt_clr) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else begin
      if (dout_valid && dout_sat[1] && (sat_hi_cnt != 16'hFFFF)) sat_hi_cnt <= sat_hi_cnt + 16'd1;
      if (dout_valid && dout_sat[0] && (sat_lo_cnt != 16'hFFFF)) sat_lo_cnt <= sat_lo_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/panel_correct_offset_sat_mc.md
# panel_correct_offset_sat_mc

Multi-coefficient panel-correction offset stage for the XT M4 coefficient path. It holds one signed offset per coefficient number in a writable table and adds the selected offset to each streamed unsigned sample. The sum saturates to the unsigned data range, and a 16-bit zero-extended result is emitted two cycles later. It replaces the fixed single-coefficient 13-bit offset adder used for coefficients 0/4/8. Offsets are loaded by the Panel Correction Command decoder.

## Interface
- DW, 13: unsigned sample width and signed offset width (2..15).
- NCOEF, 9: number of coefficient offset entries (2..64).
- AW, 4: coefficient index width, ≥ clog2(NCOEF).
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  offset-table write strobe.
- wr_addr  input  AW  coefficient number to write.
- wr_data  input  16  offset; bits [DW-1:0] are two's complement, upper bits ignored.
- din_valid  input  1  sample strobe.
- din_coef  input  AW  coefficient number of the sample.
- din  input  16  sample; bits [DW-1:0] are unsigned, upper bits ignored.
- dout_valid  output  1  result strobe.
- dout  output  16  {(16-DW) zeros, result[DW-1:0]}.
- dout_sat  output  2  saturation flags: [1] = clipped high, [0] = clipped low.
- wr_err  output  1  one-cycle pulse when wr_addr ≥ NCOEF.

## Operation
- Offset table: NCOEF × DW registers. All entries are 0 after reset.
- Write: wr_en=1 with wr_addr < NCOEF stores wr_data[DW-1:0] at the next edge.
- Write with wr_addr ≥ NCOEF leaves the table unchanged and pulses wr_err one cycle later.
- Stage 1, on din_valid: sum (DW+2 bits) = {2'b00, din[DW-1:0]} + sign-extended offset[din_coef]. A din_coef ≥ NCOEF uses offset 0.
- Stage 2 decodes sum[DW+1:DW]:
  - 00: result = sum[DW-1:0], sat = 00.
  - 01: result = all ones, sat = 10.
  - 10 or 11: result = 0, sat = 01.
- Invalid cycles still advance the pipeline. dout, dout_sat and the valid bits of a bubble are 0; dout holds 0, not the previous value.
- Write and sample to the same coefficient in the same cycle: the sample uses the old offset. The new offset applies from the next cycle.

## Timing
- Latency is 2 cycles: a sample with din_valid at edge n gives dout_valid at edge n+2. Throughput is one sample per cycle with no backpressure.
- Write-to-use is 1 cycle: a write at edge n affects samples presented from edge n+1 onward.
- Reset values: dout=0, dout_valid=0, dout_sat=0, wr_err=0, table=0, pipeline valids=0.
- Reset asserted mid-stream clears in-flight samples immediately (asynchronously). No dout_valid is produced for them after rst deasserts.
- Release of rst is synchronised externally. The first sample is accepted on the first edge with rst=0.

## Configuration
- PANEL_CORRECT_SAT_CNT_EN defined:
  - Adds outputs sat_hi_cnt[15:0] and sat_lo_cnt[15:0], plus input cnt_clr.
  - Each counter increments on a dout_valid cycle with the matching flag set. Counters saturate at 16'hFFFF and do not wrap.
  - cnt_clr zeroes both counters synchronously and takes priority over increment. Reset value is 0.
- Macro undefined: the counters and their ports are absent, and all other behaviour is identical.

## Test plan
- Reset, then stream with all offsets 0 (DW=13): din=0x1234 on coef 3 -> dout=0x1234, sat=00, valid exactly 2 cycles later; no valid during bubbles.
- Write offset[4]=0x0010, then din=0x1FF8 on coef 4 -> dout=0x1FFF, sat=10. Write offset[8]=0x1FF0 (-16), then din=0x0005 on coef 8 -> dout=0x0000, sat=01.
- Same-cycle write offset[0]=0x0100 and sample din=0x0100 on coef 0 -> dout=0x0100. Next-cycle sample din=0x0100 -> dout=0x0200.
- Write to wr_addr=9 with NCOEF=9 -> wr_err pulses one cycle and the table is unchanged. Sample with din_coef=12, din=0x0ABC -> dout=0x0ABC.
- Assert rst while two samples are in flight -> no dout_valid afterwards, all outputs 0, table reads back 0.
- With PANEL_CORRECT_SAT_CNT_EN: offset[1]=0x0FFF, 3 samples din=0x1800 -> sat_hi_cnt=3. Pulse cnt_clr in the same cycle as a 4th saturating result -> counter=0.
